// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter that lets N_CH sources take turns driving one shared tri-state bus.
// A registered output enable and an enforced high-Z turnaround keep any two drivers from overlapping.
module tristate_bus_arbiter #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1,
  localparam int OW        = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*WIDTH-1:0]   din,
  output logic [N_CH-1:0]         gnt,
  output logic [OW-1:0]           owner,
  output logic                    oe,
  inout  wire  [WIDTH-1:0]        bus,
  output logic [WIDTH-1:0]        bus_q,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t          state, state_n;
  logic [N_CH-1:0] gnt_n;
  logic [OW-1:0]   owner_n;
  logic            oe_n;
  logic [OW-1:0]   rr_ptr, rr_n;
  logic [7:0]      beat_cnt, beat_n;
  logic [3:0]      turn_cnt, turn_n;
  logic [OW-1:0]   sel;
  logic            found;
  logic [WIDTH-1:0] bus_drv;

  // Pick the first requester at or above rr_ptr, wrapping around the top.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
  end

  always_comb begin
    bus_drv = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (owner == OW'(k)) bus_drv = din[k*WIDTH +: WIDTH];
    end
  end

  assign bus  = oe ? bus_drv : {WIDTH{1'bz}};
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    oe_n    = oe;
    rr_n    = rr_ptr;
    beat_n  = beat_cnt;
    turn_n  = turn_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = DRIVE;
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          owner_n    = sel;
          oe_n       = 1'b1;
          beat_n     = 8'd0;
          rr_n       = (sel == OW'(N_CH - 1)) ? '0 : sel + OW'(1);
        end
      end
      DRIVE: begin
        // The cycle in which the owner drops its request is still driven.
        if (!req[owner] || beat_cnt == 8'(MAX_BURST - 1)) begin
          state_n = TURN;
          gnt_n   = '0;
          oe_n    = 1'b0;
          turn_n  = 4'd0;
        end else begin
          beat_n = beat_cnt + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt == 4'(TURNAROUND - 1)) begin
          state_n = IDLE;
        end else begin
          turn_n = turn_cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        oe_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      oe       <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= 8'd0;
      turn_cnt <= 4'd0;
      bus_q    <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      oe       <= oe_n;
      rr_ptr   <= rr_n;
      beat_cnt <= beat_n;
      turn_cnt <= turn_n;
      if (oe) bus_q <= bus_drv;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: default instance plus a 2-channel, 16-bit,
// 3-cycle-turnaround instance.
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        oe;
  wire  [7:0]  bus;
  logic [7:0]  bus_q;
  logic        busy;

  logic [1:0]  req2;
  logic [31:0] din2;
  logic [1:0]  gnt2;
  logic        owner2;
  logic        oe2;
  wire  [15:0] bus2;
  logic [15:0] bus_q2;
  logic        busy2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N_CH(4), .WIDTH(8), .MAX_BURST(4), .TURNAROUND(1)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt), .owner(owner),
    .oe(oe), .bus(bus), .bus_q(bus_q), .busy(busy)
  );

  tristate_bus_arbiter #(.N_CH(2), .WIDTH(16), .MAX_BURST(4), .TURNAROUND(3)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .din(din2), .gnt(gnt2), .owner(owner2),
    .oe(oe2), .bus(bus2), .bus_q(bus_q2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; din = '0; req2 = '0; din2 = '0;
    tick; tick;
    reset = 1'b0;
    tests_run++; if (gnt !== 4'b0)   begin tests_failed++; $display("[TB] FAIL reset_gnt got %h want 0", gnt); end
    tests_run++; if (oe !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_oe got %b want 0", oe); end
    tests_run++; if (owner !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_owner got %0d want 0", owner); end
    tests_run++; if (busy !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (bus_q !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_bus_q got %h want 0", bus_q); end
    tests_run++; if (oe2 !== 1'b0 || busy2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dut2 got oe=%b busy=%b want 0 0", oe2, busy2); end
  endtask

  task automatic test_reset_mid_burst;
    req = 4'b0001; din[7:0] = 8'hA5;
    tick;
    tests_run++; if (oe !== 1'b1 || gnt !== 4'b0001) begin tests_failed++; $display("[TB] FAIL midrst_grant got oe=%b gnt=%b want 1 0001", oe, gnt); end
    tests_run++; if (bus !== 8'hA5) begin tests_failed++; $display("[TB] FAIL midrst_bus got %h want a5", bus); end
    tick;
    tests_run++; if (oe !== 1'b1 || bus_q !== 8'hA5) begin tests_failed++; $display("[TB] FAIL midrst_beat2 got oe=%b bus_q=%h want 1 a5", oe, bus_q); end
    reset = 1'b1;
    tick;
    reset = 1'b0; req = '0;
    tests_run++; if (oe !== 1'b0 || gnt !== 4'b0) begin tests_failed++; $display("[TB] FAIL midrst_after got oe=%b gnt=%b want 0 0000", oe, gnt); end
    tests_run++; if (busy !== 1'b0 || bus_q !== 8'h0) begin tests_failed++; $display("[TB] FAIL midrst_state got busy=%b bus_q=%h want 0 00", busy, bus_q); end
  endtask

  task automatic test_single;
    req = 4'b0100; din[23:16] = 8'h3C;
    tick;
    tests_run++; if (gnt !== 4'b0100 || owner !== 2'd2) begin tests_failed++; $display("[TB] FAIL single_gnt got gnt=%b owner=%0d want 0100 2", gnt, owner); end
    tests_run++; if (oe !== 1'b1 || bus !== 8'h3C || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_drive1 got oe=%b bus=%h busy=%b want 1 3c 1", oe, bus, busy); end
    tick;
    req = 4'b0000;
    tests_run++; if (oe !== 1'b1 || bus !== 8'h3C) begin tests_failed++; $display("[TB] FAIL single_drive2 got oe=%b bus=%h want 1 3c", oe, bus); end
    tick;
    tests_run++; if (oe !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_turn got oe=%b gnt=%b busy=%b want 0 0000 1", oe, gnt, busy); end
    tests_run++; if (bus_q !== 8'h3C) begin tests_failed++; $display("[TB] FAIL single_bus_q got %h want 3c", bus_q); end
    tick;
    tests_run++; if (oe !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle got oe=%b busy=%b want 0 0", oe, busy); end
  endtask

  task automatic test_burst_limit;
    logic exp_oe;
    req = 4'b0010; din[15:8] = 8'h5A;
    for (int c = 0; c < 12; c++) begin
      tick;
      exp_oe = ((c % 6) < 4);
      tests_run++; if (oe !== exp_oe) begin tests_failed++; $display("[TB] FAIL burst_oe c=%0d got %b want %b", c, oe, exp_oe); end
      tests_run++; if (gnt !== (exp_oe ? 4'b0010 : 4'b0000)) begin tests_failed++; $display("[TB] FAIL burst_gnt c=%0d got %b want %b", c, gnt, exp_oe ? 4'b0010 : 4'b0000); end
      if (exp_oe) begin
        tests_run++; if (bus !== 8'h5A) begin tests_failed++; $display("[TB] FAIL burst_bus c=%0d got %h want 5a", c, bus); end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin;
    int k;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      k = g % 4;
      for (int b = 0; b < 4; b++) begin
        tick;
        tests_run++; if (oe !== 1'b1 || gnt !== 4'(1 << k) || owner !== 2'(k)) begin tests_failed++; $display("[TB] FAIL rr_grant g=%0d b=%0d got oe=%b gnt=%b owner=%0d want 1 %b %0d", g, b, oe, gnt, owner, 4'(1 << k), k); end
        tests_run++; if (bus !== din[k*8 +: 8]) begin tests_failed++; $display("[TB] FAIL rr_bus g=%0d got %h want %h", g, bus, din[k*8 +: 8]); end
      end
      tick;
      tests_run++; if (oe !== 1'b0 || gnt !== 4'b0) begin tests_failed++; $display("[TB] FAIL rr_turn g=%0d got oe=%b gnt=%b want 0 0000", g, oe, gnt); end
      tick;
      tests_run++; if (oe !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_idle g=%0d got oe=%b busy=%b want 0 0", g, oe, busy); end
    end
    req = 4'b0000;
    tick;
  endtask

  // rr_ptr is 1 on entry: ch2 short grant, ch3 raised mid-grant must wait.
  task automatic test_back_to_back;
    req = 4'b0100;
    tick;
    tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("[TB] FAIL b2b_first got %b want 0100", gnt); end
    req = 4'b1100;
    tick;
    tests_run++; if (gnt !== 4'b0100 || oe !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_hold got gnt=%b oe=%b want 0100 1", gnt, oe); end
    req = 4'b1000;
    tick;
    tests_run++; if (oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_turn got oe=%b want 0", oe); end
    tick;
    tests_run++; if (oe !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle got oe=%b busy=%b want 0 0", oe, busy); end
    tick;
    tests_run++; if (gnt !== 4'b1000 || owner !== 2'd3 || oe !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second got gnt=%b owner=%0d oe=%b want 1000 3 1", gnt, owner, oe); end
    req = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_random;
    logic       last_oe;
    logic [3:0] prev_req;
    int         zero_run;
    int         drive_run;
    last_oe = 1'b0; prev_req = req; zero_run = 99; drive_run = 0;
    for (int c = 0; c < 600; c++) begin
      tick;
      req = 4'($urandom_range(0, 15));
      din = $urandom;
      #1;
      tests_run++; if (gnt !== (oe ? 4'(1 << owner) : 4'b0)) begin tests_failed++; $display("[TB] FAIL rand_gnt c=%0d got gnt=%b oe=%b owner=%0d", c, gnt, oe, owner); end
      if (oe) begin
        tests_run++; if (bus !== din[owner*8 +: 8]) begin tests_failed++; $display("[TB] FAIL rand_bus c=%0d got %h want %h", c, bus, din[owner*8 +: 8]); end
        if (!last_oe) begin
          tests_run++; if (zero_run < 2) begin tests_failed++; $display("[TB] FAIL rand_gap c=%0d got %0d want >=2", c, zero_run); end
          tests_run++; if (prev_req[owner] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_req c=%0d owner %0d granted without request %b", c, owner, prev_req); end
          drive_run = 0;
        end
        drive_run++;
        tests_run++; if (drive_run > 4) begin tests_failed++; $display("[TB] FAIL rand_burst c=%0d got %0d want <=4", c, drive_run); end
        zero_run = 0;
      end else begin
        zero_run++;
      end
      last_oe  = oe;
      prev_req = req;
    end
    req = 4'b0000;
    for (int c = 0; c < 8; c++) tick;
  endtask

  task automatic test_param_sweep;
    logic exp_oe;
    int   own;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    din2 = {16'hBEEF, 16'h1234};
    req2 = 2'b11;
    for (int c = 0; c < 24; c++) begin
      tick;
      exp_oe = ((c % 8) < 4);
      own    = (c / 8) % 2;
      tests_run++; if (oe2 !== exp_oe) begin tests_failed++; $display("[TB] FAIL sweep_oe c=%0d got %b want %b", c, oe2, exp_oe); end
      if (exp_oe) begin
        tests_run++; if (owner2 !== 1'(own) || gnt2 !== 2'(1 << own)) begin tests_failed++; $display("[TB] FAIL sweep_owner c=%0d got owner=%0d gnt=%b want %0d", c, owner2, gnt2, own); end
        tests_run++; if (bus2 !== din2[own*16 +: 16]) begin tests_failed++; $display("[TB] FAIL sweep_bus c=%0d got %h want %h", c, bus2, din2[own*16 +: 16]); end
      end else begin
        tests_run++; if (gnt2 !== 2'b00) begin tests_failed++; $display("[TB] FAIL sweep_gap_gnt c=%0d got %b want 00", c, gnt2); end
      end
    end
    req2 = 2'b00;
    tests_run++; if (bus_q2 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL sweep_bus_q got %h want 1234", bus_q2); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_burst;
    test_single;
    test_burst_limit;
    test_round_robin;
    test_back_to_back;
    test_random;
    test_param_sweep;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
